gray_monitor: RTL and testbench
===============================

# gray_monitor

Consumer stage placed directly downstream of the 3-bit Gray-code counter. Each cycle it samples the counter's code and overflow flag, decodes the code to binary, checks that every change is a legal single step, and extends the count with a saturating lap counter. Any illegal transition or overflow inconsistency latches a sticky fault until reset, so the counter can be checked in-system.

## Interface
- LAP_W, 8: width of lap counter Laps.
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high; clock Clk.
- Gray  input  3  Gray code from the counter (its Output).
- Ovf  input  1  sticky overflow flag from the counter (its Overflow).
- Bin  output  3  registered binary decode of last accepted code.
- Laps  output  LAP_W  completed forward wraps (7->0), saturating.
- Step  output  1  one-cycle pulse: a legal forward step was accepted.
- Back  output  1  one-cycle pulse: a legal backward step was accepted (only with GRAY_MON_BACKWARD_EN; otherwise tied 0).
- Err  output  1  sticky fault flag.

## Operation
- Decode: b[2]=g[2]; b[1]=g[2]^g[1]; b[0]=b[1]^g[0]. d = decode(Gray), p = Bin (previous accepted value), o = registered previous Ovf.
- FSM states INIT, TRACK, FAULT.
- INIT: entered on Reset. Next edge: Bin<=d, o<=Ovf, no checks, no pulses, go TRACK.
- TRACK, evaluated in priority order each edge:
  - Ovf=1 and o=0 and not (p=7, d=0): FAULT.
  - d=p: hold; Step=0.
  - d=p+1 mod 8: Bin<=d, Step=1. If p=7, d=0 (wrap): Ovf must be 1, otherwise FAULT; Laps<=Laps+1 unless all-ones (saturate, stay).
  - d=p-1 mod 8: with macro, legal backward step (see Configuration); without macro, FAULT.
  - Any other d: FAULT.
  - o<=Ovf every TRACK cycle.
- FAULT: Err=1; Bin, Laps frozen at last legal values; Step=Back=0; leave only via Reset.
- Entry into FAULT happens on the same edge the violation is sampled; Bin/Laps are not updated on that edge.
- Arithmetic: 3-bit comparisons are mod 8; Laps is unsigned LAP_W-bit.

## Timing
- Reset values: Bin=0, Laps=0, Step=0, Back=0, Err=0, o=0, state INIT.
- Latency: Gray sampled at edge N appears on Bin/Step/Laps after edge N (one-cycle registered latency); Err rises after the edge that samples the violation.
- Step/Back are single-cycle pulses; a code held for k cycles gives exactly one pulse.
- Reset mid-operation (any state, including FAULT): all outputs return to reset values on that edge; INIT follows.
- Reset has priority over every other event in the same cycle.
- Ovf staying 1 after the first wrap is legal; later wraps need no new Ovf edge.

## Configuration
- GRAY_MON_BACKWARD_EN defined: d=p-1 mod 8 is legal. Bin<=d, Back=1. If p=0, d=7 (unwrap): Laps decrements. At Laps=0 an unwrap is a FAULT. No Ovf check on backward steps.
- Undefined: backward steps are FAULT; Back is constant 0.

## Structure
- Package gray_mon_pkg: state enum (INIT, TRACK, FAULT) and the 3-bit code width constant.
- One combinational sub-module gray2bin (3-bit Gray to binary), instantiated once for d.
- Everything else (FSM, lap counter, Ovf edge tracking) lives in gray_monitor.

## Test plan
- Reset, then feed 000,001,011,010,110,111,101,100,000 with Ovf rising together with the final 000 -> Bin 0..7,0; Step pulses 8 times; Laps=1; Err=0.
- Continue the full cycle 3 more times with Ovf held 1 -> Laps=4; Err=0. With LAP_W=2, one further wrap -> Laps stays 3.
- From Bin=2 (Gray 011), apply Gray 110 -> Err=1 next cycle; Bin stays 2. Later legal codes -> no change until Reset.
- Wrap 100->000 with Ovf=0 -> Err=1. Separately, Ovf rising at Bin=3 -> Err=1.
- Macro defined: from Bin=0, apply Gray 001 then 000 then 100 -> Step, Back, then FAULT because Laps=0. Macro undefined: Gray 001 then 000 -> Err=1.
- Assert Reset while in FAULT with Laps=5 -> next cycle Bin=0, Laps=0, Err=0. The first following sample is accepted without a check.

Source files
------------

// File: rtl/gray_mon_pkg.sv
// Shared types and constants for the Gray-code counter monitor.
package gray_mon_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/gray_monitor_gray2bin.sv
// Purely combinational Gray-to-binary decoder: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray2bin
  import gray_mon_pkg::*;
(
  input  logic [CODE_W-1:0] i_gray,
  output logic [CODE_W-1:0] o_bin
);

  genvar gi;
  generate
    for (gi = 0; gi < CODE_W; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[CODE_W-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_monitor.sv
// In-system checker for the 3-bit Gray counter: decodes, tracks laps, latches faults.
// Optional macro GRAY_MON_BACKWARD_EN makes single backward steps legal (Back pulse, lap decrement).
module gray_monitor
  import gray_mon_pkg::*;
#(
  parameter int LAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [CODE_W-1:0] Gray,
  input  logic              Ovf,
  output logic [CODE_W-1:0] Bin,
  output logic [LAP_W-1:0]  Laps,
  output logic              Step,
  output logic              Back,
  output logic              Err
);

  state_t              r_state, w_state_next;
  logic [CODE_W-1:0]   r_bin, w_bin_next;
  logic [LAP_W-1:0]    r_laps, w_laps_next;
  logic                r_step, w_step_next;
  logic                r_back, w_back_next;
  logic                r_ovf, w_ovf_next;

  logic [CODE_W-1:0]   w_d;
  logic [CODE_W-1:0]   w_inc;
  logic                w_fwd;
  logic                w_wrap;

  gray2bin u_dec (
    .i_gray (Gray),
    .o_bin  (w_d)
  );

  assign w_inc  = r_bin + CODE_W'(1);
  assign w_fwd  = (w_d == w_inc);
  assign w_wrap = (r_bin == '1) && (w_d == '0);

`ifdef GRAY_MON_BACKWARD_EN
  logic [CODE_W-1:0]   w_dec;
  logic                w_bwd;
  logic                w_unwrap;
  assign w_dec    = r_bin - CODE_W'(1);
  assign w_bwd    = (w_d == w_dec);
  assign w_unwrap = (r_bin == '0) && (w_d == '1);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= INIT;
      r_bin   <= '0;
      r_laps  <= '0;
      r_step  <= 1'b0;
      r_back  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_bin   <= w_bin_next;
      r_laps  <= w_laps_next;
      r_step  <= w_step_next;
      r_back  <= w_back_next;
      r_ovf   <= w_ovf_next;
    end
  end

  // Violation checks run in strict priority order; any fault leaves Bin/Laps untouched.
  always_comb begin
    w_state_next = r_state;
    w_bin_next   = r_bin;
    w_laps_next  = r_laps;
    w_step_next  = 1'b0;
    w_back_next  = 1'b0;
    w_ovf_next   = r_ovf;
    case (r_state)
      INIT: begin
        w_bin_next   = w_d;
        w_ovf_next   = Ovf;
        w_state_next = TRACK;
      end
      TRACK: begin
        w_ovf_next = Ovf;
        if (Ovf && !r_ovf && !w_wrap) begin
          w_state_next = FAULT;
        end else if (w_d == r_bin) begin
          w_bin_next = r_bin;
        end else if (w_fwd) begin
          if (w_wrap && !Ovf) begin
            w_state_next = FAULT;
          end else begin
            w_bin_next  = w_d;
            w_step_next = 1'b1;
            if (w_wrap && (r_laps != '1)) w_laps_next = r_laps + LAP_W'(1);
          end
        end
`ifdef GRAY_MON_BACKWARD_EN
        else if (w_bwd) begin
          if (w_unwrap && (r_laps == '0)) begin
            w_state_next = FAULT;
          end else begin
            w_bin_next  = w_d;
            w_back_next = 1'b1;
            if (w_unwrap) w_laps_next = r_laps - LAP_W'(1);
          end
        end
`endif
        else begin
          w_state_next = FAULT;
        end
      end
      FAULT: begin
        w_state_next = FAULT;
      end
      default: begin
        w_state_next = INIT;
      end
    endcase
  end

  assign Bin  = r_bin;
  assign Laps = r_laps;
  assign Step = r_step;
  assign Back = r_back;
  assign Err  = (r_state == FAULT);

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor: directed scenarios plus random walks,
// checked against a table-driven behavioural model of the monitoring rules.
module tb_gray_monitor;

  localparam int LW   = 3;
  localparam int LMAX = (1 << LW) - 1;
`ifdef GRAY_MON_BACKWARD_EN
  localparam bit BACK_EN = 1'b1;
`else
  localparam bit BACK_EN = 1'b0;
`endif

  logic          Clk   = 1'b0;
  logic          Reset = 1'b1;
  logic [2:0]    Gray  = 3'b000;
  logic          Ovf   = 1'b0;
  logic [2:0]    Bin;
  logic [LW-1:0] Laps;
  logic          Step;
  logic          Back;
  logic          Err;

  always #5 Clk = ~Clk;

  gray_monitor #(.LAP_W(LW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Gray  (Gray),
    .Ovf   (Ovf),
    .Bin   (Bin),
    .Laps  (Laps),
    .Step  (Step),
    .Back  (Back),
    .Err   (Err)
  );

  typedef struct packed {
    logic [2:0]    bin;
    logic [LW-1:0] laps;
    logic          step;
    logic          back;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 = waiting for first sample, 1 = tracking, 2 = faulted
  int m_state = 0;
  int m_bin   = 0;
  int m_laps  = 0;
  bit m_o     = 1'b0;
  bit m_step  = 1'b0;
  bit m_back  = 1'b0;

  int cur     = 0;
  bit ovf_cur = 1'b0;

  function automatic logic [2:0] enc(input int b);
    int v;
    v = b ^ (b >> 1);
    return v[2:0];
  endfunction

  // Decode by searching the Gray sequence rather than by XOR folding.
  function automatic int decode(input logic [2:0] g);
    for (int i = 0; i < 8; i++) begin
      if (enc(i) == g) return i;
    end
    return 0;
  endfunction

  task automatic model(input logic [2:0] g, input bit ovf, input bit rst);
    int d;
    bit wrap, unwrap;
    d      = decode(g);
    m_step = 1'b0;
    m_back = 1'b0;
    if (rst) begin
      m_state = 0; m_bin = 0; m_laps = 0; m_o = 1'b0;
    end else if (m_state == 0) begin
      m_bin = d; m_o = ovf; m_state = 1;
    end else if (m_state == 1) begin
      wrap   = (m_bin == 7) && (d == 0);
      unwrap = (m_bin == 0) && (d == 7);
      if (ovf && !m_o && !wrap) begin
        m_state = 2;
      end else if (d == m_bin) begin
        m_step = 1'b0;
      end else if (d == (m_bin + 1) % 8) begin
        if (wrap && !ovf) m_state = 2;
        else begin
          m_bin  = d;
          m_step = 1'b1;
          if (wrap && m_laps < LMAX) m_laps = m_laps + 1;
        end
      end else if (BACK_EN && d == (m_bin + 7) % 8) begin
        if (unwrap && m_laps == 0) m_state = 2;
        else begin
          m_bin  = d;
          m_back = 1'b1;
          if (unwrap) m_laps = m_laps - 1;
        end
      end else begin
        m_state = 2;
      end
      m_o = ovf;
    end
  endtask

  task automatic drive(input logic [2:0] g, input bit ovf, input bit rst);
    exp_t e;
    @(negedge Clk);
    Gray  = g;
    Ovf   = ovf;
    Reset = rst;
    model(g, ovf, rst);
    e.bin  = 3'(m_bin);
    e.laps = LW'(m_laps);
    e.step = m_step;
    e.back = m_back;
    e.err  = (m_state == 2);
    q.push_back(e);
  endtask

  task automatic do_reset();
    drive(3'b000, 1'b0, 1'b1);
    cur = 0;
  endtask

  task automatic walk_to(input int b, input bit ovf);
    while (cur != b) begin
      cur = (cur + 1) % 8;
      drive(enc(cur), ovf, 1'b0);
    end
  endtask

  task automatic full_laps(input int n, input bit ovf);
    for (int k = 0; k < n * 8; k++) begin
      cur = (cur + 1) % 8;
      drive(enc(cur), ovf, 1'b0);
    end
  endtask

  // Monitor: every cycle the DUT presents a result one step after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (Bin !== e.bin || Laps !== e.laps || Step !== e.step ||
            Back !== e.back || Err !== e.err) begin
          errors++;
          $display("FAIL txn%0d: got bin=%0d laps=%0d step=%0b back=%0b err=%0b, need bin=%0d laps=%0d step=%0b back=%0b err=%0b",
                   checks, Bin, Laps, Step, Back, Err, e.bin, e.laps, e.step, e.back, e.err);
        end else begin
          $display("txn%0d gray=%b ovf=%0b rst=%0b -> bin=%0d laps=%0d step=%0b back=%0b err=%0b",
                   checks, Gray, Ovf, Reset, Bin, Laps, Step, Back, Err);
        end
      end
    end
  end

  initial begin
    int r;
    // Reset state, then one clean lap with Ovf rising on the wrap.
    do_reset();
    do_reset();
    drive(enc(0), 1'b0, 1'b0);
    walk_to(7, 1'b0);
    cur = 0;
    drive(enc(0), 1'b1, 1'b0);
    drive(enc(0), 1'b1, 1'b0);
    drive(enc(0), 1'b1, 1'b0);
    full_laps(3, 1'b1);
    full_laps(5, 1'b1);

    // Illegal jump from Bin=2 to Gray 110, then legal codes are ignored.
    do_reset();
    drive(enc(0), 1'b0, 1'b0);
    walk_to(2, 1'b0);
    drive(3'b110, 1'b0, 1'b0);
    cur = 2;
    walk_to(5, 1'b0);

    // Wrap without overflow.
    do_reset();
    drive(enc(0), 1'b0, 1'b0);
    walk_to(7, 1'b0);
    drive(enc(0), 1'b0, 1'b0);
    drive(enc(1), 1'b0, 1'b0);

    // Overflow rising away from a wrap.
    do_reset();
    drive(enc(0), 1'b0, 1'b0);
    walk_to(3, 1'b0);
    drive(enc(3), 1'b1, 1'b0);
    drive(enc(4), 1'b1, 1'b0);

    // Backward steps: 001 then 000 then 100.
    do_reset();
    drive(enc(0), 1'b0, 1'b0);
    drive(3'b001, 1'b0, 1'b0);
    drive(3'b000, 1'b0, 1'b0);
    drive(3'b100, 1'b0, 1'b0);
    drive(3'b100, 1'b0, 1'b0);

    // Reach Laps=5, fault, reset out of FAULT, first sample unchecked.
    do_reset();
    drive(enc(0), 1'b1, 1'b0);
    full_laps(5, 1'b1);
    drive(3'b110, 1'b1, 1'b0);
    drive(enc(1), 1'b1, 1'b0);
    do_reset();
    drive(3'b101, 1'b0, 1'b0);
    drive(enc(7), 1'b0, 1'b0);

    // Random walk: mostly legal moves, occasional holds, reversals, jumps, resets.
    do_reset();
    ovf_cur = 1'b0;
    cur = $urandom_range(0, 7);
    drive(enc(cur), ovf_cur, 1'b0);
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 199);
      if (r < 2) begin
        do_reset();
        ovf_cur = 1'b0;
        cur = $urandom_range(0, 7);
        drive(enc(cur), ovf_cur, 1'b0);
      end else begin
        if (r < 110)      cur = (cur + 1) % 8;
        else if (r < 150) cur = cur;
        else if (r < 180) cur = (cur + 7) % 8;
        else              cur = $urandom_range(0, 7);
        if (cur == 0 && $urandom_range(0, 9) != 0) ovf_cur = 1'b1;
        else if ($urandom_range(0, 99) < 2)        ovf_cur = ~ovf_cur;
        drive(enc(cur), ovf_cur, 1'b0);
      end
    end

    repeat (3) @(negedge Clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, need 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
